// File: rtl/tick_to_level_stretcher_pkg.sv
// rtl/tick_to_level_stretcher_pkg.sv - state encoding and sizing helper for the tick stretcher
package tick_to_level_stretcher_pkg;

   // Encodings are fixed so that other blocks sharing these states agree on them
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } stretch_state_t;

   // Width of a down-counter that must hold max(high_cycles, gap_cycles)
   function automatic int cnt_width(input int high_cycles, input int gap_cycles);
      int span;
      span = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
      return $clog2(span + 1);
   endfunction

endpackage

// File: rtl/tick_to_level_stretcher_sat_updown_counter.sv
// rtl/tick_to_level_stretcher_sat_updown_counter.sv - saturating up/down counter for queued ticks
module sat_updown_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         sat
);

   localparam logic [W-1:0] COUNT_MAX = {W{1'b1}};

   // Full flag; the owner uses it to decide whether an increment is dropped
   assign sat = (count == COUNT_MAX);

   // Simultaneous inc and dec cancel; never wraps in either direction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && !sat) begin
         count <= count + 1'b1;
      end else if (dec && !inc && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/tick_to_level_stretcher.sv
// rtl/tick_to_level_stretcher.sv - turns single-cycle ticks into spaced, fixed-width level pulses
module tick_to_level_stretcher
   import tick_to_level_stretcher_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 3,
   parameter int RETRIGGER   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              clr_ovf,
   output logic              level,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int CNT_W = cnt_width(HIGH_CYCLES, GAP_CYCLES);
   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam bit RETRIG = (RETRIGGER != 0);

   stretch_state_t   state;
   stretch_state_t   state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             pend_inc;
   logic             pend_dec;
   logic             pend_sat;
   logic             drop;

   // Ticks that cannot start a pulse right now are held here until a gap ends
   sat_updown_counter #(
      .W (PEND_W)
   ) u_pending (
      .clk   (clk),
      .rst   (rst),
      .inc   (pend_inc),
      .dec   (pend_dec),
      .count (pending),
      .sat   (pend_sat)
   );

   // Next-state and cycle counter; a tick landing on the final gap cycle is
   // counted and consumed in the same edge so it starts the next pulse directly
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pend_inc  = 1'b0;
      pend_dec  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (tick) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = HIGH_LOAD;
            end
         end
         ST_HIGH: begin
            if (tick && RETRIG) begin
               cnt_nxt = HIGH_LOAD;
            end else if (cnt == '0) begin
               state_nxt = ST_GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
            pend_inc = tick && !RETRIG;
         end
         ST_GAP: begin
            pend_inc = tick;
            if (cnt == '0) begin
               if ((pending != '0) || tick) begin
                  state_nxt = ST_HIGH;
                  cnt_nxt   = HIGH_LOAD;
                  pend_dec  = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // A tick is lost only when the queue is full and nothing leaves it this edge
   assign drop = pend_inc && pend_sat && !pend_dec;

   // State, counter and registered outputs; reset drops the level immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         level    <= 1'b0;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         level    <= (state_nxt == ST_HIGH);
         busy     <= (state_nxt != ST_IDLE);
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tick_to_level_stretcher.sv
// tb/tb_tick_to_level_stretcher.sv - scoreboard bench for the tick stretcher
module tb_tick_to_level_stretcher;

   localparam int H    = 4;
   localparam int G    = 2;
   localparam int PW   = 3;
   localparam int PMAX = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          tick;
   logic          clr_ovf;
   logic          level;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   logic          tick_rt;
   logic          clr_rt;
   logic          level_rt;
   logic          busy_rt;
   logic [PW-1:0] pending_rt;
   logic          overflow_rt;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc;
   int   rises[$];
   int   sb[$];
   int   next_free;
   logic m_ovf;
   logic prev_level;
   int   det_count;
   int   tick_count;

   tick_to_level_stretcher #(
      .HIGH_CYCLES (H), .GAP_CYCLES (G), .PEND_W (PW), .RETRIGGER (0)
   ) u_dut (
      .clk (clk), .rst (rst), .tick (tick), .clr_ovf (clr_ovf),
      .level (level), .busy (busy), .pending (pending), .overflow (overflow)
   );

   tick_to_level_stretcher #(
      .HIGH_CYCLES (H), .GAP_CYCLES (G), .PEND_W (PW), .RETRIGGER (1)
   ) u_dut_rt (
      .clk (clk), .rst (rst), .tick (tick_rt), .clr_ovf (clr_rt),
      .level (level_rt), .busy (busy_rt), .pending (pending_rt), .overflow (overflow_rt)
   );

   always #5 clk = ~clk;

   // Timing model: a pulse rises at max(tick edge, previous rise + H + G)
   function automatic int count_after(input int k);
      int n = 0;
      foreach (rises[i]) if (rises[i] > k) n++;
      return n;
   endfunction

   function automatic logic exp_level(input int k);
      logic v = 1'b0;
      foreach (rises[i]) if (rises[i] <= k && k <= rises[i] + H - 1) v = 1'b1;
      return v;
   endfunction

   function automatic logic exp_busy(input int k);
      logic v = 1'b0;
      foreach (rises[i]) if (rises[i] <= k && k <= rises[i] + H + G - 1) v = 1'b1;
      return v;
   endfunction

   task automatic clear_model();
      rises.delete();
      sb.delete();
      next_free  = 0;
      m_ovf      = 1'b0;
      cyc        = 0;
      prev_level = 1'b0;
      det_count  = 0;
      tick_count = 0;
   endtask

   task automatic model_edge(input logic t, input logic c);
      int r;
      if (c) m_ovf = 1'b0;
      if (t) begin
         if (count_after(cyc) < PMAX) begin
            r = (cyc > next_free) ? cyc : next_free;
            rises.push_back(r);
            sb.push_back(r);
            next_free = r + H + G;
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step(input logic t, input logic c);
      logic [PW-1:0] ep;
      int r;
      tick    = t;
      clr_ovf = c;
      @(posedge clk);
      model_edge(t, c);
      #1;
      ep = PW'(count_after(cyc));
      n_checks++;
      if (level !== exp_level(cyc)) $display("FAIL level k=%0d got=%b want=%b", cyc, level, exp_level(cyc));
      else n_pass++;
      n_checks++;
      if (busy !== exp_busy(cyc)) $display("FAIL busy k=%0d got=%b want=%b", cyc, busy, exp_busy(cyc));
      else n_pass++;
      n_checks++;
      if (pending !== ep) $display("FAIL pending k=%0d got=%0d want=%0d", cyc, pending, ep);
      else n_pass++;
      n_checks++;
      if (overflow !== m_ovf) $display("FAIL overflow k=%0d got=%b want=%b", cyc, overflow, m_ovf);
      else n_pass++;
      if (level === 1'b1 && prev_level === 1'b0) begin
         det_count++;
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected_pulse k=%0d got=rise want=none", cyc);
         end else begin
            r = sb.pop_front();
            if (r !== cyc) $display("FAIL sb_rise_edge got=%0d want=%0d", cyc, r);
            else n_pass++;
         end
      end
      prev_level = level;
      cyc++;
      @(negedge clk);
      tick    = 1'b0;
      clr_ovf = 1'b0;
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (sb.size() != 0) $display("FAIL %s_drained got=%0d_left want=0", name, sb.size());
      else n_pass++;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick = 1'b0; clr_ovf = 1'b0; tick_rt = 1'b0; clr_rt = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({level, busy, pending, overflow} !== '0)
         $display("FAIL reset_outputs got=%b want=0", {level, busy, pending, overflow});
      else n_pass++;
      n_checks++;
      if ({level_rt, busy_rt, pending_rt, overflow_rt} !== '0)
         $display("FAIL reset_outputs_rt got=%b want=0", {level_rt, busy_rt, pending_rt, overflow_rt});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_single();
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         step(k == 0, 1'b0);
         n_checks++;
         if (level !== (k <= 3)) $display("FAIL single_level k=%0d got=%b want=%b", k, level, (k <= 3));
         else n_pass++;
         n_checks++;
         if (busy !== (k <= 5)) $display("FAIL single_busy k=%0d got=%b want=%b", k, busy, (k <= 5));
         else n_pass++;
      end
      check_drained("single");
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int k = 0; k < 14; k++) begin
         step(k <= 1, 1'b0);
         if (k == 1 || k == 6) begin
            n_checks++;
            if (pending !== ((k == 1) ? 3'd1 : 3'd0))
               $display("FAIL b2b_pending k=%0d got=%0d want=%0d", k, pending, (k == 1) ? 1 : 0);
            else n_pass++;
         end
      end
      check_drained("b2b");
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int k = 0; k < 12; k++) step(1'b1, k == 10);
      n_checks++;
      if (overflow !== 1'b1) $display("FAIL sat_overflow_set got=%b want=1", overflow);
      else n_pass++;
      for (int k = 12; k < 75; k++) step(1'b0, 1'b0);
      n_checks++;
      if (det_count != rises.size()) $display("FAIL sat_pulse_count got=%0d want=%0d", det_count, rises.size());
      else n_pass++;
      step(1'b0, 1'b1);
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL sat_overflow_clear got=%b want=0", overflow);
      else n_pass++;
      check_drained("sat");
   endtask

   task automatic test_last_gap_tick();
      apply_reset();
      for (int k = 0; k < 14; k++) begin
         step(k == 0 || k == 5, 1'b0);
         n_checks++;
         if (pending > 3'd1) $display("FAIL gap5_pending_max k=%0d got=%0d want<=1", k, pending);
         else n_pass++;
      end
      check_drained("gap5");
      apply_reset();
      for (int k = 0; k < 14; k++) begin
         step(k == 0 || k == 6, 1'b0);
         if (k == 6) begin
            n_checks++;
            if (pending !== 3'd0 || level !== 1'b1)
               $display("FAIL gap_end_tick got=p%0d_l%b want=p0_l1", pending, level);
            else n_pass++;
         end
      end
      check_drained("gap_end");
   endtask

   task automatic test_reset_mid_pulse();
      apply_reset();
      for (int k = 0; k < 4; k++) step(k <= 2, 1'b0);
      n_checks++;
      if (pending !== 3'd2) $display("FAIL mid_pending_before got=%0d want=2", pending);
      else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({level, busy, pending, overflow} !== '0)
         $display("FAIL mid_async_reset got=%b want=0", {level, busy, pending, overflow});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      for (int k = 0; k < 15; k++) step(1'b0, 1'b0);
      n_checks++;
      if (det_count != 0) $display("FAIL mid_no_resume got=%0d want=0", det_count);
      else n_pass++;
   endtask

   task automatic test_loopback();
      int gap;
      apply_reset();
      for (int i = 0; i < 25; i++) begin
         step(1'b1, 1'b0);
         tick_count++;
         gap = $urandom_range(7, 11);
         repeat (gap - 1) step(1'b0, 1'b0);
      end
      repeat (12) step(1'b0, 1'b0);
      n_checks++;
      if (det_count != tick_count) $display("FAIL loop_edges got=%0d want=%0d", det_count, tick_count);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL loop_overflow got=%b want=0", overflow);
      else n_pass++;
      check_drained("loop");
   endtask

   task automatic test_retrigger();
      apply_reset();
      for (int k = 0; k < 12; k++) begin
         tick_rt = (k == 0 || k == 2);
         @(posedge clk);
         #1;
         n_checks++;
         if (level_rt !== (k <= 5)) $display("FAIL rt_level k=%0d got=%b want=%b", k, level_rt, (k <= 5));
         else n_pass++;
         n_checks++;
         if (busy_rt !== (k <= 7)) $display("FAIL rt_busy k=%0d got=%b want=%b", k, busy_rt, (k <= 7));
         else n_pass++;
         n_checks++;
         if (pending_rt !== 3'd0) $display("FAIL rt_pending k=%0d got=%0d want=0", k, pending_rt);
         else n_pass++;
         @(negedge clk);
         tick_rt = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0; clr_ovf = 1'b0; tick_rt = 1'b0; clr_rt = 1'b0;
      clear_model();
      test_reset();
      test_single();
      test_back_to_back();
      test_saturation();
      test_last_gap_tick();
      test_reset_mid_pulse();
      test_loopback();
      test_retrigger();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
